// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
// Purpose: fetch FSM state encoding, the canonical NOP word and the PC increment.
// Ports: none (package).
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam int          PC_STEP   = 4;

endpackage

// File: rtl/instr_store.sv
// rtl/instr_store.sv - DEPTH x XLEN instruction array, sync write, async read
// Purpose: program store loaded while the fetch stage is idle; contents are not reset.
// Ports:
//   clk    in  clock for the write port
//   we     in  write enable
//   waddr  in  word index written
//   wdata  in  word written
//   raddr  in  word index read (combinational)
//   rdata  out word at raddr
module instr_store #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [XLEN-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [XLEN-1:0]          rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - loadable instruction store with stepping/stalling/redirecting PC
// Purpose: presents one registered instruction per cycle to the decoder with a valid flag.
// Ports:
//   clk, rst (async, active-low)
//   load_en/load_addr/load_data  program load, honoured only in IDLE
//   run                          level: 1 = fetch, 0 = return to IDLE
//   stall                        downstream not ready, hold PC and outputs
//   redirect_valid/redirect_pc   taken branch/jump target (byte address)
//   instr_valid/instr/pc_out     registered fetch result (instr feeds the decoder)
//   fault                        sticky misaligned/out-of-range fetch
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [XLEN-1:0]          load_data,
  input  logic                     run,
  input  logic                     stall,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     instr_valid,
  output logic [XLEN-1:0]          instr,
  output logic [XLEN-1:0]          pc_out,
  output logic                     fault
);

  localparam int              AW   = $clog2(DEPTH);
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_d, pc_out_d;
  logic            valid_d, fault_d;
  logic [XLEN-1:0] rdata;

  // A PC is fetchable only if word-aligned and no bit above the store index is set.
  function automatic logic pc_ok(input logic [XLEN-1:0] a);
    return (a[1:0] == 2'b00) && (a[XLEN-1:AW+2] == '0);
  endfunction

  instr_store #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_store (
    .clk   (clk),
    .we    (load_en && (state_q == IDLE)),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc_q[AW+1:2]),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= '0;
      pc_out      <= '0;
      fault       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_valid <= valid_d;
      instr       <= instr_d;
      pc_out      <= pc_out_d;
      fault       <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr;
    pc_out_d = pc_out;
    valid_d  = instr_valid;
    fault_d  = fault;
    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!run) begin
          state_d = IDLE;
          valid_d = 1'b0;
          pc_d    = RESET_PC;
        end else if (redirect_valid) begin
          valid_d = 1'b0;
          if (!pc_ok(redirect_pc)) begin
            state_d = HALT;
            fault_d = 1'b1;
          end else begin
            pc_d = redirect_pc;
          end
        end else if (!stall) begin
          // After the last word pc has stepped past the store: halt rather than wrap.
          if (!pc_ok(pc_q)) begin
            state_d = HALT;
            fault_d = 1'b1;
            valid_d = 1'b0;
          end else begin
            instr_d  = rdata;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + STEP;
          end
        end
      end
      HALT: begin
        valid_d = 1'b0;
        if (!run) begin
          state_d = IDLE;
          fault_d = 1'b0;
          pc_d    = RESET_PC;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        load_en;
  logic [2:0]  load_addr;
  logic [31:0] load_data;
  logic        run;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        fault;

  int total = 0;
  int bad   = 0;

  instr_fetch #(
    .XLEN     (32),
    .DEPTH    (8),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .load_en        (load_en),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .run            (run),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .pc_out         (pc_out),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, ".valid"}, 32'(instr_valid), 32'(v));
    chk({tag, ".pc"}, pc_out, pc);
    chk({tag, ".instr"}, instr, ins);
  endtask

  // Bring the stage out of IDLE and take the fetch of word 0.
  task automatic start_run(input string tag);
    run = 1'b1;
    step();
    chk({tag, ".enter"}, 32'(instr_valid), 32'd0);
    step();
    chk_out({tag, ".w0"}, 1'b1, 32'd0, 32'h1000_0000);
  endtask

  task automatic stop_run(input string tag);
    run = 1'b0;
    step();
    chk({tag, ".idle_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, ".idle_fault"}, 32'(fault), 32'd0);
  endtask

  task automatic bad_redirect(input string tag, input logic [31:0] tgt);
    start_run(tag);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    step();
    redirect_valid = 1'b0;
    chk({tag, ".fault"}, 32'(fault), 32'd1);
    chk({tag, ".valid"}, 32'(instr_valid), 32'd0);
    step();
    chk({tag, ".halt_fault"}, 32'(fault), 32'd1);
    stop_run(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b0;
    load_en        = 1'b0;
    load_addr      = '0;
    load_data      = '0;
    run            = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #2;
    chk_out("reset", 1'b0, 32'd0, 32'd0);
    chk("reset.fault", 32'(fault), 32'd0);
    step();
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      load_en   = 1'b1;
      load_addr = 3'(i);
      load_data = 32'h1000_0000 + 32'(i);
      step();
    end
    load_en = 1'b0;

    // Straight run through the whole store, then halt on running off the end.
    start_run("run1");
    for (int k = 1; k < 8; k++) begin
      step();
      chk_out($sformatf("run1.w%0d", k), 1'b1, 32'(4 * k), 32'h1000_0000 + 32'(k));
    end
    step();
    chk("run1.end_fault", 32'(fault), 32'd1);
    chk("run1.end_valid", 32'(instr_valid), 32'd0);
    stop_run("run1");

    // Stall at pc_out=8 for 3 cycles, with an ignored load to word 3.
    start_run("stall");
    step();
    step();
    chk_out("stall.w2", 1'b1, 32'd8, 32'h1000_0002);
    stall     = 1'b1;
    load_en   = 1'b1;
    load_addr = 3'd3;
    load_data = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_out($sformatf("stall.hold%0d", k), 1'b1, 32'd8, 32'h1000_0002);
    end
    stall   = 1'b0;
    load_en = 1'b0;
    step();
    chk_out("stall.w3", 1'b1, 32'd12, 32'h1000_0003);
    stop_run("stall");

    // Redirect to 20 from pc_out=4 with stall also asserted.
    start_run("redir");
    step();
    chk_out("redir.w1", 1'b1, 32'd4, 32'h1000_0001);
    redirect_valid = 1'b1;
    redirect_pc    = 32'd20;
    stall          = 1'b1;
    step();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    chk("redir.bubble", 32'(instr_valid), 32'd0);
    step();
    chk_out("redir.tgt", 1'b1, 32'd20, 32'h1000_0005);
    stop_run("redir");

    bad_redirect("mis6", 32'd6);
    bad_redirect("oor32", 32'd32);

    // Reset pulse between edges mid-fetch; the store must survive.
    start_run("rst");
    step();
    #2;
    rst = 1'b0;
    #1;
    chk_out("rst.async", 1'b0, 32'd0, 32'd0);
    chk("rst.fault", 32'(fault), 32'd0);
    rst = 1'b1;
    step();
    chk("rerun.enter", 32'(instr_valid), 32'd0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk_out($sformatf("rerun.w%0d", k), 1'b1, 32'(4 * k), 32'h1000_0000 + 32'(k));
    end
    step();
    chk("rerun.end_fault", 32'(fault), 32'd1);
    stop_run("rerun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
